// File: rtl/ifft_top.sv
// 8-point inverse FFT, 16-bit signed complex data, one radix-2 DIT butterfly per clock.
// Result is scaled by 1/8 (one halving per stage); busy_o while working, valid_o pulses once per result.
module ifft_top (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic signed [15:0] X_0_R_i,
  input  logic signed [15:0] X_1_R_i,
  input  logic signed [15:0] X_2_R_i,
  input  logic signed [15:0] X_3_R_i,
  input  logic signed [15:0] X_4_R_i,
  input  logic signed [15:0] X_5_R_i,
  input  logic signed [15:0] X_6_R_i,
  input  logic signed [15:0] X_7_R_i,
  input  logic signed [15:0] X_0_I_i,
  input  logic signed [15:0] X_1_I_i,
  input  logic signed [15:0] X_2_I_i,
  input  logic signed [15:0] X_3_I_i,
  input  logic signed [15:0] X_4_I_i,
  input  logic signed [15:0] X_5_I_i,
  input  logic signed [15:0] X_6_I_i,
  input  logic signed [15:0] X_7_I_i,
  output logic signed [15:0] x_0_R_o,
  output logic signed [15:0] x_1_R_o,
  output logic signed [15:0] x_2_R_o,
  output logic signed [15:0] x_3_R_o,
  output logic signed [15:0] x_4_R_o,
  output logic signed [15:0] x_5_R_o,
  output logic signed [15:0] x_6_R_o,
  output logic signed [15:0] x_7_R_o,
  output logic signed [15:0] x_0_I_o,
  output logic signed [15:0] x_1_I_o,
  output logic signed [15:0] x_2_I_o,
  output logic signed [15:0] x_3_I_o,
  output logic signed [15:0] x_4_I_o,
  output logic signed [15:0] x_5_I_o,
  output logic signed [15:0] x_6_I_o,
  output logic signed [15:0] x_7_I_o,
  output logic               valid_o,
  output logic               busy_o
);

  // S_IDLE: waiting for start_i | S_CALC: 12 butterflies, one per edge | S_DONE: publish result
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_bfly;
  logic               w_emit;
  logic [3:0]         r_cnt;
  logic signed [15:0] r_ram_re [8];
  logic signed [15:0] r_ram_im [8];
  logic signed [15:0] r_out_re [8];
  logic signed [15:0] r_out_im [8];
  logic signed [15:0] w_in_re  [8];
  logic signed [15:0] w_in_im  [8];

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  assign w_in_re[0] = X_0_R_i;  assign w_in_im[0] = X_0_I_i;
  assign w_in_re[1] = X_1_R_i;  assign w_in_im[1] = X_1_I_i;
  assign w_in_re[2] = X_2_R_i;  assign w_in_im[2] = X_2_I_i;
  assign w_in_re[3] = X_3_R_i;  assign w_in_im[3] = X_3_I_i;
  assign w_in_re[4] = X_4_R_i;  assign w_in_im[4] = X_4_I_i;
  assign w_in_re[5] = X_5_R_i;  assign w_in_im[5] = X_5_I_i;
  assign w_in_re[6] = X_6_R_i;  assign w_in_im[6] = X_6_I_i;
  assign w_in_re[7] = X_7_R_i;  assign w_in_im[7] = X_7_I_i;

  assign x_0_R_o = r_out_re[0];  assign x_0_I_o = r_out_im[0];
  assign x_1_R_o = r_out_re[1];  assign x_1_I_o = r_out_im[1];
  assign x_2_R_o = r_out_re[2];  assign x_2_I_o = r_out_im[2];
  assign x_3_R_o = r_out_re[3];  assign x_3_I_o = r_out_im[3];
  assign x_4_R_o = r_out_re[4];  assign x_4_I_o = r_out_im[4];
  assign x_5_R_o = r_out_re[5];  assign x_5_I_o = r_out_im[5];
  assign x_6_R_o = r_out_re[6];  assign x_6_I_o = r_out_im[6];
  assign x_7_R_o = r_out_re[7];  assign x_7_I_o = r_out_im[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_bfly      = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      S_IDLE: if (start_i) begin
        w_state_nxt = S_CALC;
        w_load      = 1'b1;
      end
      S_CALC: begin
        w_bfly = 1'b1;
        if (r_cnt == 4'd11) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);

  // Butterfly addressing: r_cnt[3:2] is the stage, r_cnt[1:0] the butterfly within it.
  logic [1:0] w_stage;
  logic [1:0] w_k;
  logic [2:0] w_a_idx;
  logic [2:0] w_b_idx;
  logic [1:0] w_tw_idx;

  assign w_stage = r_cnt[3:2];
  assign w_k     = r_cnt[1:0];

  always_comb begin
    w_a_idx  = 3'd0;
    w_b_idx  = 3'd0;
    w_tw_idx = 2'd0;
    case (w_stage)
      2'd0: begin
        w_a_idx  = {w_k, 1'b0};
        w_b_idx  = {w_k, 1'b1};
        w_tw_idx = 2'd0;
      end
      2'd1: begin
        w_a_idx  = {w_k[1], 1'b0, w_k[0]};
        w_b_idx  = {w_k[1], 1'b1, w_k[0]};
        w_tw_idx = {w_k[0], 1'b0};
      end
      default: begin
        w_a_idx  = {1'b0, w_k};
        w_b_idx  = {1'b1, w_k};
        w_tw_idx = w_k;
      end
    endcase
  end

  // Q2.14 twiddles e^{+j*pi*m/4}, m = 0..3
  logic signed [15:0] w_tw_re;
  logic signed [15:0] w_tw_im;

  always_comb begin
    w_tw_re = 16'sd16384;
    w_tw_im = 16'sd0;
    case (w_tw_idx)
      2'd0: begin w_tw_re =  16'sd16384; w_tw_im = 16'sd0;     end
      2'd1: begin w_tw_re =  16'sd11585; w_tw_im = 16'sd11585; end
      2'd2: begin w_tw_re =  16'sd0;     w_tw_im = 16'sd16384; end
      default: begin w_tw_re = -16'sd11585; w_tw_im = 16'sd11585; end
    endcase
  end

  logic signed [15:0] w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [31:0] w_b_re32, w_b_im32, w_tw_re32, w_tw_im32;
  logic signed [31:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [31:0] w_sum_re, w_sum_im;
  logic signed [17:0] w_t_re, w_t_im;
  logic signed [17:0] w_a_re_x, w_a_im_x;
  logic signed [17:0] w_s_re, w_s_im, w_d_re, w_d_im;

  assign w_a_re = r_ram_re[w_a_idx];
  assign w_a_im = r_ram_im[w_a_idx];
  assign w_b_re = r_ram_re[w_b_idx];
  assign w_b_im = r_ram_im[w_b_idx];

  assign w_b_re32  = {{16{w_b_re[15]}}, w_b_re};
  assign w_b_im32  = {{16{w_b_im[15]}}, w_b_im};
  assign w_tw_re32 = {{16{w_tw_re[15]}}, w_tw_re};
  assign w_tw_im32 = {{16{w_tw_im[15]}}, w_tw_im};

  assign w_p_rr = w_b_re32 * w_tw_re32;
  assign w_p_ii = w_b_im32 * w_tw_im32;
  assign w_p_ri = w_b_re32 * w_tw_im32;
  assign w_p_ir = w_b_im32 * w_tw_re32;

  assign w_sum_re = w_p_rr - w_p_ii;
  assign w_sum_im = w_p_ri + w_p_ir;
  assign w_t_re   = 18'(w_sum_re >>> 14);
  assign w_t_im   = 18'(w_sum_im >>> 14);

  // 18 bits hold |a| + |t| <= 32768 + 46341 without wrap; bits [16:1] are the halved result.
  assign w_a_re_x = {{2{w_a_re[15]}}, w_a_re};
  assign w_a_im_x = {{2{w_a_im[15]}}, w_a_im};
  assign w_s_re   = w_a_re_x + w_t_re;
  assign w_s_im   = w_a_im_x + w_t_im;
  assign w_d_re   = w_a_re_x - w_t_re;
  assign w_d_im   = w_a_im_x - w_t_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        r_ram_re[i] <= 16'sd0;
        r_ram_im[i] <= 16'sd0;
      end
    end else if (w_load) begin
      r_cnt <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        r_ram_re[i] <= w_in_re[bitrev3(3'(i))];
        r_ram_im[i] <= w_in_im[bitrev3(3'(i))];
      end
    end else if (w_bfly) begin
      r_cnt             <= r_cnt + 4'd1;
      r_ram_re[w_a_idx] <= w_s_re[16:1];
      r_ram_im[w_a_idx] <= w_s_im[16:1];
      r_ram_re[w_b_idx] <= w_d_re[16:1];
      r_ram_im[w_b_idx] <= w_d_im[16:1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_out_re[i] <= 16'sd0;
        r_out_im[i] <= 16'sd0;
      end
    end else begin
      valid_o <= w_emit;
      if (w_emit) begin
        for (int i = 0; i < 8; i++) begin
          r_out_re[i] <= r_ram_re[i];
          r_out_im[i] <= r_ram_im[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ifft_top.sv
// Bench for ifft_top: directed spectra, random vectors against a loop-based IFFT model,
// start-ignore, back-to-back and reset-abort scenarios.
module tb_ifft_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic signed [15:0] xr_in [8];
  logic signed [15:0] xi_in [8];
  logic signed [15:0] yr [8];
  logic signed [15:0] yi [8];
  logic valid_o, busy_o;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] ld_re [8];
  logic signed [15:0] ld_im [8];
  logic signed [15:0] ld2_re [8];
  logic signed [15:0] ld2_im [8];
  int exp_re [8];
  int exp_im [8];

  bit ob_busy [16];
  bit ob_valid [16];
  int ob_re [8];
  int ob_im [8];
  bit ob_changed;
  int ob_vcount;

  always #5 clk = ~clk;

  ifft_top dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .X_0_R_i(xr_in[0]), .X_1_R_i(xr_in[1]), .X_2_R_i(xr_in[2]), .X_3_R_i(xr_in[3]),
    .X_4_R_i(xr_in[4]), .X_5_R_i(xr_in[5]), .X_6_R_i(xr_in[6]), .X_7_R_i(xr_in[7]),
    .X_0_I_i(xi_in[0]), .X_1_I_i(xi_in[1]), .X_2_I_i(xi_in[2]), .X_3_I_i(xi_in[3]),
    .X_4_I_i(xi_in[4]), .X_5_I_i(xi_in[5]), .X_6_I_i(xi_in[6]), .X_7_I_i(xi_in[7]),
    .x_0_R_o(yr[0]), .x_1_R_o(yr[1]), .x_2_R_o(yr[2]), .x_3_R_o(yr[3]),
    .x_4_R_o(yr[4]), .x_5_R_o(yr[5]), .x_6_R_o(yr[6]), .x_7_R_o(yr[7]),
    .x_0_I_o(yi[0]), .x_1_I_o(yi[1]), .x_2_I_o(yi[2]), .x_3_I_o(yi[3]),
    .x_4_I_o(yi[4]), .x_5_I_o(yi[5]), .x_6_I_o(yi[6]), .x_7_I_o(yi[7]),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  // Radix-2 DIT IFFT over plain integers: bit-reversed load, three halving stages.
  task automatic compute_model();
    int mr[8], mi[8];
    int twr[4], twi[4];
    twr = '{16384, 11585, 0, -11585};
    twi = '{0, 11585, 16384, 11585};
    for (int r = 0; r < 8; r++) begin
      int br;
      br = ((r & 1) << 2) | (r & 2) | ((r >> 2) & 1);
      mr[r] = int'(ld_re[br]);
      mi[r] = int'(ld_im[br]);
    end
    for (int s = 0; s < 3; s++) begin
      int h;
      h = 1 << s;
      for (int a = 0; a < 8; a++) begin
        if ((a & h) == 0) begin
          int b, ti, tr, tim, nar, nai, nbr, nbi;
          b  = a + h;
          ti = (a & (h - 1)) * (4 >> s);
          tr  = (mr[b] * twr[ti] - mi[b] * twi[ti]) >>> 14;
          tim = (mr[b] * twi[ti] + mi[b] * twr[ti]) >>> 14;
          tr  = (tr <<< 14) >>> 14;
          tim = (tim <<< 14) >>> 14;
          nar = (((mr[a] + tr) >>> 1) <<< 16) >>> 16;
          nai = (((mi[a] + tim) >>> 1) <<< 16) >>> 16;
          nbr = (((mr[a] - tr) >>> 1) <<< 16) >>> 16;
          nbi = (((mi[a] - tim) >>> 1) <<< 16) >>> 16;
          mr[a] = nar; mi[a] = nai; mr[b] = nbr; mi[b] = nbi;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      exp_re[n] = mr[n];
      exp_im[n] = mi[n];
    end
  endtask

  task automatic clear_ld();
    for (int n = 0; n < 8; n++) begin
      ld_re[n] = 16'sd0;
      ld_im[n] = 16'sd0;
    end
  endtask

  task automatic random_ld();
    for (int n = 0; n < 8; n++) begin
      ld_re[n] = 16'($urandom);
      ld_im[n] = 16'($urandom);
    end
  endtask

  // mode 0: single start; 1: extra start requests before E5 and E13; 2: new start at E14 with ld2.
  task automatic run_xform(input int mode);
    int pre_re[8], pre_im[8];
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      xr_in[n] = ld_re[n];
      xi_in[n] = ld_im[n];
      pre_re[n] = int'(yr[n]);
      pre_im[n] = int'(yi[n]);
    end
    start_i = 1'b1;
    ob_changed = 1'b0;
    ob_vcount = 0;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ob_busy[i] = busy_o;
      ob_valid[i] = valid_o;
      if (valid_o === 1'b1) ob_vcount++;
      for (int n = 0; n < 8; n++) begin
        if (i <= 12 && (int'(yr[n]) != pre_re[n] || int'(yi[n]) != pre_im[n])) ob_changed = 1'b1;
        if (i == 13) begin
          ob_re[n] = int'(yr[n]);
          ob_im[n] = int'(yi[n]);
        end
        xr_in[n] = 16'($urandom);
        xi_in[n] = 16'($urandom);
      end
      start_i = (mode == 1) && (i + 1 == 5 || i + 1 == 13);
      if (mode == 2 && i == 13) begin
        for (int n = 0; n < 8; n++) begin
          xr_in[n] = ld2_re[n];
          xi_in[n] = ld2_im[n];
        end
        start_i = 1'b1;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b valid=%b expected 0 0", busy_o, valid_o);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (yr[n] !== 16'sd0 || yi[n] !== 16'sd0) begin
        failures++;
        $display("FAIL reset_out[%0d] got (%0d,%0d) expected (0,0)", n, yr[n], yi[n]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    clear_ld();
    ld_re[0] = 16'sd8;
    run_xform(0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ob_busy[i] !== (i <= 12) || ob_valid[i] !== (i == 13)) begin
        failures++;
        $display("FAIL impulse_timing after E%0d busy=%b valid=%b expected busy=%b valid=%b",
                 i, ob_busy[i], ob_valid[i], (i <= 12), (i == 13));
      end
    end
    checks++;
    if (ob_changed !== 1'b0) begin
      failures++;
      $display("FAIL impulse_hold outputs changed during CALC got=1 expected=0");
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ob_re[n] != 1 || ob_im[n] != 0) begin
        failures++;
        $display("FAIL impulse_x[%0d] got (%0d,%0d) expected (1,0)", n, ob_re[n], ob_im[n]);
      end
    end
  endtask

  task automatic test_constant();
    for (int n = 0; n < 8; n++) begin
      ld_re[n] = 16'sd800;
      ld_im[n] = 16'sd0;
    end
    run_xform(0);
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ob_re[n] != (n == 0 ? 800 : 0) || ob_im[n] != 0) begin
        failures++;
        $display("FAIL constant_x[%0d] got (%0d,%0d) expected (%0d,0)", n, ob_re[n], ob_im[n],
                 (n == 0 ? 800 : 0));
      end
    end
  endtask

  task automatic test_tone();
    int tr[8], ti[8];
    tr = '{100, 70, 0, -70, -100, -70, 0, 70};
    ti = '{0, 70, 100, 70, 0, -70, -100, -70};
    clear_ld();
    ld_re[1] = 16'sd800;
    compute_model();
    run_xform(0);
    for (int n = 0; n < 8; n++) begin
      int tol;
      tol = (n % 2 == 1) ? 1 : 0;
      checks++;
      if (ob_re[n] - tr[n] > tol || tr[n] - ob_re[n] > tol ||
          ob_im[n] - ti[n] > tol || ti[n] - ob_im[n] > tol) begin
        failures++;
        $display("FAIL tone_x[%0d] got (%0d,%0d) expected (%0d,%0d) tol %0d",
                 n, ob_re[n], ob_im[n], tr[n], ti[n], tol);
      end
      checks++;
      if (ob_re[n] != exp_re[n] || ob_im[n] != exp_im[n]) begin
        failures++;
        $display("FAIL tone_model_x[%0d] got (%0d,%0d) expected (%0d,%0d)",
                 n, ob_re[n], ob_im[n], exp_re[n], exp_im[n]);
      end
    end
  endtask

  task automatic test_full_scale();
    clear_ld();
    ld_re[0] = -16'sd32768;
    run_xform(0);
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ob_re[n] != -4096 || ob_im[n] != 0) begin
        failures++;
        $display("FAIL full_scale_x[%0d] got (%0d,%0d) expected (-4096,0)", n, ob_re[n], ob_im[n]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      random_ld();
      compute_model();
      run_xform(0);
      checks++;
      if (ob_vcount != 1) begin
        failures++;
        $display("FAIL random_valid_count it=%0d got %0d expected 1", it, ob_vcount);
      end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (ob_re[n] != exp_re[n] || ob_im[n] != exp_im[n]) begin
          failures++;
          $display("FAIL random_x[%0d] it=%0d got (%0d,%0d) expected (%0d,%0d)",
                   n, it, ob_re[n], ob_im[n], exp_re[n], exp_im[n]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    random_ld();
    compute_model();
    run_xform(1);
    checks++;
    if (ob_vcount != 1) begin
      failures++;
      $display("FAIL ignore_valid_count got %0d expected 1", ob_vcount);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ob_busy[i] !== (i <= 12)) begin
        failures++;
        $display("FAIL ignore_busy after E%0d got %b expected %b", i, ob_busy[i], (i <= 12));
      end
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ob_re[n] != exp_re[n] || ob_im[n] != exp_im[n]) begin
        failures++;
        $display("FAIL ignore_x[%0d] got (%0d,%0d) expected (%0d,%0d)",
                 n, ob_re[n], ob_im[n], exp_re[n], exp_im[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int wait_n;
    bit seen;
    random_ld();
    for (int n = 0; n < 8; n++) begin
      ld2_re[n] = 16'($urandom);
      ld2_im[n] = 16'($urandom);
    end
    compute_model();
    run_xform(2);
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ob_re[n] != exp_re[n] || ob_im[n] != exp_im[n]) begin
        failures++;
        $display("FAIL b2b_first_x[%0d] got (%0d,%0d) expected (%0d,%0d)",
                 n, ob_re[n], ob_im[n], exp_re[n], exp_im[n]);
      end
    end
    checks++;
    if (ob_busy[14] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept_E14 busy=%b expected 1", ob_busy[14]);
    end
    for (int n = 0; n < 8; n++) begin
      ld_re[n] = ld2_re[n];
      ld_im[n] = ld2_im[n];
    end
    compute_model();
    wait_n = 0;
    seen = 1'b0;
    while (!seen && wait_n < 30) begin
      @(negedge clk);
      wait_n++;
      if (valid_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || wait_n != 12) begin
      failures++;
      $display("FAIL b2b_second_latency seen=%b cycles=%0d expected seen=1 cycles=12", seen, wait_n);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (int'(yr[n]) != exp_re[n] || int'(yi[n]) != exp_im[n]) begin
        failures++;
        $display("FAIL b2b_second_x[%0d] got (%0d,%0d) expected (%0d,%0d)",
                 n, yr[n], yi[n], exp_re[n], exp_im[n]);
      end
    end
  endtask

  task automatic test_abort();
    int vseen;
    random_ld();
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      xr_in[n] = ld_re[n];
      xi_in[n] = ld_im[n];
    end
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags busy=%b valid=%b expected 0 0", busy_o, valid_o);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (yr[n] !== 16'sd0 || yi[n] !== 16'sd0) begin
        failures++;
        $display("FAIL abort_out[%0d] got (%0d,%0d) expected (0,0)", n, yr[n], yi[n]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || busy_o !== 1'b0) vseen++;
    end
    checks++;
    if (vseen != 0) begin
      failures++;
      $display("FAIL abort_no_valid active cycles=%0d expected 0", vseen);
    end
  endtask

  initial begin
    for (int n = 0; n < 8; n++) begin
      xr_in[n] = 16'sd0;
      xi_in[n] = 16'sd0;
    end
    test_reset();
    test_impulse();
    test_constant();
    test_tone();
    test_full_scale();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_impulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
